// File: rtl/do_ashr_pkg.sv
// Shared parameters and types for the do_ashr registered right shifter.
package do_ashr_pkg;

    localparam int unsigned DATA_W_DEF  = 3;
    localparam int unsigned SHAMT_W_DEF = 36;
    localparam int unsigned SHIDX_W     = $clog2(DATA_W_DEF);

    typedef enum logic {
        LOGICAL = 1'b0,
        ARITH   = 1'b1
    } shift_mode_e;

    function automatic int unsigned shidx_w(input int unsigned data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/do_ashr_sat_cmp.sv
// Wide unsigned compare of a shift amount against DATA_W; yields the saturation
// flag and the truncated in-range index (meaningful only when sat=0).
module do_ashr_sat_cmp
    import do_ashr_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic [SHAMT_W-1:0]         shamt,
    output logic                       sat,
    output logic [shidx_w(DATA_W)-1:0] idx
);

    localparam int unsigned IDX_W = shidx_w(DATA_W);
    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(DATA_W);

    if (SHAMT_W > IDX_W) begin : g_wide
        logic             high;
        logic [IDX_W-1:0] low;

        // any bit at or above 2**IDX_W already exceeds DATA_W-1
        assign high = |shamt[SHAMT_W-1:IDX_W];
        assign low  = shamt[IDX_W-1:0];
        assign sat  = high | ({1'b0, low} >= LIMIT);
        assign idx  = low;
    end else begin : g_narrow
        logic [IDX_W:0] ext;

        assign ext = (IDX_W + 1)'(shamt);
        assign sat = (ext >= LIMIT);
        assign idx = ext[IDX_W-1:0];
    end

endmodule

// File: rtl/do_ashr.sv
// Registered right shifter with full-width shift amount, arithmetic or logical.
// Optional out_sat port enabled by defining DO_ASHR_SAT_FLAG_EN.
module do_ashr
    import do_ashr_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data
`ifdef DO_ASHR_SAT_FLAG_EN
    ,
    output logic               out_sat
`endif
);

    localparam int unsigned IDX_W = shidx_w(DATA_W);
    localparam logic [DATA_W-1:0] ONES = '1;

    shift_mode_e       mode;
    logic              fill;
    logic              sat;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] stage [0:IDX_W];
    logic [DATA_W-1:0] result;

    do_ashr_sat_cmp #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_sat_cmp (
        .shamt (in_shamt),
        .sat   (sat),
        .idx   (idx)
    );

    always_comb begin
        mode = shift_mode_e'(in_arith);
        fill = (mode == ARITH) & in_data[DATA_W-1];
    end

    assign stage[0] = in_data;

    // log-depth barrel: stage s shifts by 2**s and ORs the fill into vacated MSBs
    for (genvar s = 0; s < IDX_W; s++) begin : g_stage
        localparam int unsigned STEP = 1 << s;
        assign stage[s+1] = idx[s] ? ((stage[s] >> STEP) | (fill ? ~(ONES >> STEP) : '0))
                                   : stage[s];
    end

    always_comb begin
        result = sat ? {DATA_W{fill}} : stage[IDX_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= result;
            end
        end
    end

`ifdef DO_ASHR_SAT_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sat <= 1'b0;
        end else if (in_valid) begin
            out_sat <= sat;
        end
    end
`endif

endmodule

// File: tb/tb_do_ashr.sv
// Self-checking bench for do_ashr: directed vector table, hold/reset sequences,
// and randomized traffic against a behavioural model.
module tb_do_ashr;

    localparam int unsigned DW = 3;
    localparam int unsigned SW = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic          in_arith = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef DO_ASHR_SAT_FLAG_EN
    logic          out_sat;
`endif

    int checks = 0;
    int errors = 0;

    do_ashr #(
        .DATA_W  (DW),
        .SHAMT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef DO_ASHR_SAT_FLAG_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] shamt;
        logic          arith;
        logic [DW-1:0] exp_data;
        logic          exp_sat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer shift with explicit saturation handling
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [SW-1:0] sh,
                                            input logic ar);
        int v;
        int amt;
        bit neg;
        neg = ar && d[DW-1];
        if (sh >= SW'(DW)) return neg ? '1 : '0;
        amt = int'(sh);
        v = neg ? int'(d) - (1 << DW) : int'(d);
        v = v >>> amt;
        return v[DW-1:0];
    endfunction

    function automatic logic model_sat(input logic [SW-1:0] sh);
        return sh >= SW'(DW);
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] sh,
                         input logic ar);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_shamt = sh;
        in_arith = ar;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_data;
    logic          exp_sat;
    logic [SW-1:0] sh;

    initial begin
        vecs[0]  = '{3'b011, 36'hF_FFFF_FFFF, 1'b1, 3'b000, 1'b1};
        vecs[1]  = '{3'b100, 36'hF_FFFF_FFFF, 1'b1, 3'b111, 1'b1};
        vecs[2]  = '{3'b100, 36'hF_FFFF_FFFF, 1'b0, 3'b000, 1'b1};
        vecs[3]  = '{3'b110, 36'h1_0000_0001, 1'b1, 3'b111, 1'b1};
        vecs[4]  = '{3'b110, 36'h1_0000_0001, 1'b0, 3'b000, 1'b1};
        vecs[5]  = '{3'b101, 36'd1,           1'b1, 3'b110, 1'b0};
        vecs[6]  = '{3'b101, 36'd1,           1'b0, 3'b010, 1'b0};
        vecs[7]  = '{3'b101, 36'd2,           1'b1, 3'b111, 1'b0};
        vecs[8]  = '{3'b101, 36'd2,           1'b0, 3'b001, 1'b0};
        vecs[9]  = '{3'b101, 36'd3,           1'b1, 3'b111, 1'b1};
        vecs[10] = '{3'b101, 36'd3,           1'b0, 3'b000, 1'b1};
        vecs[11] = '{3'b011, 36'd4,           1'b1, 3'b000, 1'b1};
        vecs[12] = '{3'b111, 36'h8_0000_0000, 1'b1, 3'b111, 1'b1};
        vecs[13] = '{3'b010, 36'd0,           1'b1, 3'b010, 1'b0};

        #2;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
`ifdef DO_ASHR_SAT_FLAG_EN
        check("reset_sat", 64'(out_sat), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back directed vectors
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].data, vecs[i].shamt, vecs[i].arith);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
`ifdef DO_ASHR_SAT_FLAG_EN
            check($sformatf("vec%0d_sat", i), 64'(out_sat), 64'(vecs[i].exp_sat));
`endif
        end

        // Hold: last vector was 3'b010 shifted by 0; idle inputs must not disturb it
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b101, 36'd1, 1'b1);
            check("hold_valid", 64'(out_valid), 64'd0);
            check("hold_data", 64'(out_data), 64'd2);
`ifdef DO_ASHR_SAT_FLAG_EN
            check("hold_sat", 64'(out_sat), 64'd0);
`endif
        end

        // Reset between the capture edge and the next edge
        drive(1'b1, 3'b110, 36'd1, 1'b0);
        check("pre_rst_data", 64'(out_data), 64'd3);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'b111, 36'd0, 1'b0);
        check("postrst_valid", 64'(out_valid), 64'd0);
        check("postrst_data", 64'(out_data), 64'd0);
        drive(1'b1, 3'b111, 36'd0, 1'b0);
        check("postrst_first_valid", 64'(out_valid), 64'd1);
        check("postrst_first_data", 64'(out_data), 64'd7);

        // Randomized traffic with held-value tracking
        exp_data = 3'b111;
        exp_sat  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic [DW-1:0] d;
            logic ar;
            v  = ($urandom_range(0, 3) != 0);
            d  = DW'($urandom);
            ar = 1'($urandom);
            case ($urandom_range(0, 3))
                0, 1: sh = SW'($urandom_range(0, 4));
                2:    sh = SW'(64'(1) << $urandom_range(0, SW - 1));
                default: sh = {4'($urandom), 32'($urandom)};
            endcase
            drive(v, d, sh, ar);
            if (v) begin
                exp_data = model(d, sh, ar);
                exp_sat  = model_sat(sh);
            end
            check("rand_valid", 64'(out_valid), 64'(v));
            check("rand_data", 64'(out_data), 64'(exp_data));
`ifdef DO_ASHR_SAT_FLAG_EN
            check("rand_sat", 64'(out_sat), 64'(exp_sat));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
